pipeline_hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage 64-bit pipeline.
- Drives the load-enables and bubble/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC register.
- Detects three conditions: load-use hazards (load in EX, dependent instruction in ID), taken branches resolved in EX, and data-memory wait states signalled through a req/ack handshake in MEM.

---
 rtl/pipeline_hazard_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : stall/flush controller for the 5-stage pipeline (load-use, taken branch, MEM wait).
// Latency : enables/controls are combinational from state and inputs; state/wait counter registered.
// Backpr. : a MEM access without mem_ack freezes every latch and the PC until the ack cycle.
//
// Ports:
//   clk, rst_n            clock (rising edge) / async active-low reset
//   AselWire2, BselWire2  one-hot source registers of the instruction in ID; usesB2 qualifies B
//   DselectWire3          one-hot destination in EX; lwSwFlag3/NOPWire3 describe the EX op
//   branchControlBitWire3 EX branch type (0 = none); branchTaken3 = condition true
//   lwSwFlag4, NOPWire4   MEM memory op; mem_ack completes the access this cycle
//   *_en                  PC and pipeline-latch load enables
//   bubble_idex/flush_ifid  load a NOP into ID/EX / IF/ID
//   mem_req, mem_err      data-memory request / sticky timeout flag
//   state_o               RUN=00, MEM_WAIT=01, FLUSH=10
// Optional: define HAZARD_PERF_CNT_EN to add stall_cnt[31:0] and flush_cnt[15:0] outputs.

module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned ZERO_REG    = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] AselWire2,
    input  logic [31:0] BselWire2,
    input  logic        usesB2,
    input  logic [31:0] DselectWire3,
    input  logic [1:0]  lwSwFlag3,
    input  logic        NOPWire3,
    input  logic [2:0]  branchControlBitWire3,
    input  logic        branchTaken3,
    input  logic [1:0]  lwSwFlag4,
    input  logic        NOPWire4,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        bubble_idex,
    output logic        flush_ifid,
    output logic        mem_req,
    output logic        mem_err,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } state_e;

    // The hardwired-zero register is never a real producer, so it is masked out of matches.
    localparam logic [31:0] REG_MASK    = ~(32'd1 << ZERO_REG);
    localparam logic [7:0]  TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic load_use;
    logic mem_op4;
    logic br_taken;
    logic mem_stall;

    always_comb begin
        load_use  = !NOPWire3 && (lwSwFlag3 == 2'b01) &&
                    ((|(AselWire2 & DselectWire3 & REG_MASK)) ||
                     (usesB2 && (|(BselWire2 & DselectWire3 & REG_MASK))));
        mem_op4   = !NOPWire4 && ((lwSwFlag4 == 2'b01) || (lwSwFlag4 == 2'b10));
        br_taken  = !NOPWire3 && (branchControlBitWire3 != 3'b000) && branchTaken3;
        mem_stall = mem_op4 && !mem_ack;
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        mem_req     = mem_op4;
        state_d     = RUN;
        wait_cnt_d  = 8'd0;
        mem_err_d   = mem_err_q;

        if (mem_stall) begin
            // Freeze everything; a branch in EX is re-evaluated once the ack arrives.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            state_d    = MEM_WAIT;
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
            if (wait_cnt_d >= TIMEOUT_LIM) begin
                mem_err_d = 1'b1;
            end
        end else if (br_taken) begin
            // Branch beats load-use: the dependent instruction is on the wrong path.
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            state_d     = FLUSH;
        end else if (state_q == FLUSH) begin
            // ID holds the squashed wrong-path instruction, so its load-use match is ignored.
            bubble_idex = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID one cycle; EX then holds a bubble and the hazard clears.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            bubble_idex = 1'b1;
        end

        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            bubble_idex = 1'b1;
            flush_ifid  = 1'b1;
            mem_req     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
    assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic        lu_active;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        lu_active   = load_use && !mem_stall && !br_taken && (state_q != FLUSH);
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (mem_stall || lu_active) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!mem_stall && br_taken) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
